// File: rtl/bus_slot_sequencer_pkg.sv
// Shared types and encodings for the bus slot sequencer.
// Holds the FSM state enum, slot type and decoder enable codes.
package bus_slot_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_DRIVE,
    S_GAP,
    S_FINISH
  } bus_seq_state_t;

  typedef logic [2:0] slot_t;

  // Decoder enable bundle ordered {N_E1, N_E2, E3}.
  localparam logic [2:0] EN_ON  = 3'b001;
  localparam logic [2:0] EN_OFF = 3'b110;

  function automatic logic [7:0] slot_bit(input slot_t s);
    return 8'b1 << s;
  endfunction

endpackage

// File: rtl/bus_slot_sequencer_lowest_set8.sv
// Lowest-set-bit finder over an 8-bit vector.
// Purely combinational; idx is 0 when no bit is set.
module lowest_set8
  import bus_slot_sequencer_pkg::*;
(
  input  logic [7:0] vec,
  output slot_t      idx,
  output logic       any
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = slot_t'(i);
    end
  end

endmodule

// File: rtl/bus_slot_sequencer.sv
// Walks the selected bus slots in ascending order and drives a
// 3-to-8 inverting decoder with break-before-make dead cycles.
module bus_slot_sequencer
  import bus_slot_sequencer_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int DRIVE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [7:0] slot_mask,
  input  logic       hold,
  output logic [2:0] A,
  output logic       N_E1,
  output logic       N_E2,
  output logic       E3,
  output logic       busy,
  output logic       done,
  output logic [2:0] cur_slot
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 ||
      DRIVE_CYCLES < 1 || DRIVE_CYCLES > 15) begin : g_bad_param
    $error("bus_slot_sequencer: cycle parameter out of range 1..15");
  end

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] DRIVE_LD = 4'(DRIVE_CYCLES - 1);

  bus_seq_state_t state, state_n;
  slot_t          a_q, a_n;
  logic [7:0]     pend, pend_n;
  logic [3:0]     cnt, cnt_n;
  logic [2:0]     en_q;
  logic           busy_q, done_q;

  logic [7:0]     find_in;
  slot_t          find_idx;
  logic           find_any;

  // In IDLE the finder looks at the incoming mask, otherwise at pend.
  assign find_in = (state == S_IDLE) ? slot_mask : pend;

  lowest_set8 u_find (
    .vec (find_in),
    .idx (find_idx),
    .any (find_any)
  );

  // Next-state, slot selection and counter logic.
  always_comb begin
    state_n = state;
    a_n     = a_q;
    pend_n  = pend;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (find_any) begin
            pend_n  = slot_mask & ~slot_bit(find_idx);
            a_n     = find_idx;
            cnt_n   = SETUP_LD;
            state_n = S_SETUP;
          end else begin
            state_n = S_FINISH;
          end
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          cnt_n   = DRIVE_LD;
          state_n = S_DRIVE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_DRIVE: begin
        if (!hold) begin
          if (cnt == '0) state_n = S_GAP;
          else           cnt_n   = cnt - 4'd1;
        end
      end
      S_GAP: begin
        if (find_any) begin
          pend_n  = pend & ~slot_bit(find_idx);
          a_n     = find_idx;
          cnt_n   = SETUP_LD;
          state_n = S_SETUP;
        end else begin
          state_n = S_FINISH;
        end
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // State and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state  <= S_IDLE;
      a_q    <= '0;
      pend   <= '0;
      cnt    <= '0;
      en_q   <= EN_OFF;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      a_q    <= a_n;
      pend   <= pend_n;
      cnt    <= cnt_n;
      en_q   <= (state_n == S_DRIVE) ? EN_ON : EN_OFF;
      busy_q <= (state_n != S_IDLE);
      done_q <= (state_n == S_FINISH);
    end
  end

  assign A                = a_q;
  assign cur_slot         = a_q;
  assign {N_E1, N_E2, E3} = en_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
